// File: rtl/fpu_fcsr.sv
// Floating-point CSR block: sticky fflags accrual, frm storage and a single-outstanding CSR port.
// Optional macro FPU_FCSR_TRAP_EN adds the fexc_en register (0x800) and the trap_o pulse.
module fpu_fcsr #(
    parameter int          FLAGS_W   = 5,
    parameter logic [2:0]  RESET_FRM = 3'b000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flags_valid_i,
    input  logic        overflow_i,
    input  logic        underflow_i,
    input  logic        invalid_i,
    input  logic        div_zero_i,
    input  logic        inexact_i,
    input  logic        csr_req_i,
    output logic        csr_ready_o,
    input  logic [11:0] csr_addr_i,
    input  logic [1:0]  csr_op_i,
    input  logic [31:0] csr_wdata_i,
    output logic        csr_rvalid_o,
    input  logic        csr_rready_i,
    output logic [31:0] csr_rdata_o,
    output logic        csr_err_o,
    output logic [4:0]  fflags_o,
    output logic [2:0]  frm_o,
    output logic        frm_illegal_o,
    output logic        trap_o,
    output logic        dbg_state_o
);

    if (FLAGS_W != 5) begin : g_bad_flags_w
        $error("fpu_fcsr: FLAGS_W must be 5");
    end

    // Handshake: a request is taken on an edge where csr_req_i && csr_ready_o;
    // the response is consumed on an edge where csr_rvalid_o && csr_rready_i.
    typedef enum logic {S_IDLE = 1'b0, S_RESP = 1'b1} state_e;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    state_e             state_q, state_d;
    logic [FLAGS_W-1:0] fflags_q, fflags_d, fflags_csr, accrued;
    logic [2:0]         frm_q, frm_d;
    logic [31:0]        old_val, rdata_q;
    logic [7:0]         new_val;
    logic               err_q, addr_bad, accept, trap_q, trap_d;
    logic               unused_wdata;
`ifdef FPU_FCSR_TRAP_EN
    logic [FLAGS_W-1:0] fexc_en_q, fexc_en_d;
`endif

    assign unused_wdata = ^csr_wdata_i[31:8];

    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        csr_ready_o  = (state_q == S_IDLE);
        csr_rvalid_o = (state_q == S_RESP);
        case (state_q)
            S_IDLE: if (csr_req_i) begin
                accept  = 1'b1;
                state_d = S_RESP;
            end
            S_RESP: if (csr_rready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Old value is taken from the registers, so it never includes same-cycle accrual.
    always_comb begin
        addr_bad = 1'b0;
        old_val  = '0;
        case (csr_addr_i)
            12'h001: old_val = {{(32-FLAGS_W){1'b0}}, fflags_q};
            12'h002: old_val = {29'd0, frm_q};
            12'h003: old_val = {24'd0, frm_q, fflags_q};
`ifdef FPU_FCSR_TRAP_EN
            12'h800: old_val = {{(32-FLAGS_W){1'b0}}, fexc_en_q};
`endif
            default: addr_bad = 1'b1;
        endcase
    end

    always_comb begin
        case (csr_op_i)
            OP_WRITE: new_val = csr_wdata_i[7:0];
            OP_SET:   new_val = old_val[7:0] | csr_wdata_i[7:0];
            OP_CLEAR: new_val = old_val[7:0] & ~csr_wdata_i[7:0];
            default:  new_val = old_val[7:0];
        endcase
    end

    always_comb begin
        fflags_csr = fflags_q;
        frm_d      = frm_q;
`ifdef FPU_FCSR_TRAP_EN
        fexc_en_d  = fexc_en_q;
`endif
        if (accept && csr_op_i != OP_READ) begin
            case (csr_addr_i)
                12'h001: fflags_csr = new_val[FLAGS_W-1:0];
                12'h002: frm_d = new_val[2:0];
                12'h003: begin
                    frm_d      = new_val[7:5];
                    fflags_csr = new_val[FLAGS_W-1:0];
                end
`ifdef FPU_FCSR_TRAP_EN
                12'h800: fexc_en_d = new_val[FLAGS_W-1:0];
`endif
                default: ;
            endcase
        end
    end

    // Accrued flags are OR-ed after the CSR result so a clear cannot drop a new flag.
    assign accrued  = flags_valid_i ? {invalid_i, div_zero_i, overflow_i, underflow_i, inexact_i}
                                    : '0;
    assign fflags_d = fflags_csr | accrued;

`ifdef FPU_FCSR_TRAP_EN
    assign trap_d = |(accrued & ~fflags_q & fexc_en_q);
`else
    assign trap_d = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            fflags_q <= '0;
            frm_q    <= RESET_FRM;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            trap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            fflags_q <= fflags_d;
            frm_q    <= frm_d;
            trap_q   <= trap_d;
            if (accept) begin
                rdata_q <= addr_bad ? 32'd0 : old_val;
                err_q   <= addr_bad;
            end
        end
    end

`ifdef FPU_FCSR_TRAP_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni) fexc_en_q <= '0;
        else         fexc_en_q <= fexc_en_d;
    end
`endif

    assign csr_rdata_o   = rdata_q;
    assign csr_err_o     = err_q;
    assign fflags_o      = fflags_q;
    assign frm_o         = frm_q;
    assign frm_illegal_o = (frm_q >= 3'd5);
    assign trap_o        = trap_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_fpu_fcsr.sv
// Directed bench for fpu_fcsr: behavioural fcsr model checked every cycle plus literal pins.
module tb_fpu_fcsr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flags_valid, overflow, underflow, invalid, div_zero, inexact;
    logic        csr_req, csr_ready, csr_rvalid, csr_rready, csr_err;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    logic [31:0] csr_wdata, csr_rdata;
    logic [4:0]  fflags;
    logic [2:0]  frm;
    logic        frm_illegal, trap, dbg_state;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fpu_fcsr dut (
        .clk_i(clk), .rst_ni(rst_n),
        .flags_valid_i(flags_valid), .overflow_i(overflow), .underflow_i(underflow),
        .invalid_i(invalid), .div_zero_i(div_zero), .inexact_i(inexact),
        .csr_req_i(csr_req), .csr_ready_o(csr_ready), .csr_addr_i(csr_addr),
        .csr_op_i(csr_op), .csr_wdata_i(csr_wdata), .csr_rvalid_o(csr_rvalid),
        .csr_rready_i(csr_rready), .csr_rdata_o(csr_rdata), .csr_err_o(csr_err),
        .fflags_o(fflags), .frm_o(frm), .frm_illegal_o(frm_illegal), .trap_o(trap),
        .dbg_state_o(dbg_state)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the architectural state and the response slot.
    logic [4:0]  m_ff, m_fexc;
    logic [2:0]  m_frm;
    logic        m_busy, m_trap, m_err, m_live = 1'b0;
    logic [31:0] m_rdata;

    always @(posedge clk) begin : model
        logic [4:0]  acc, nff, nexc;
        logic [2:0]  nfrm;
        logic [31:0] old, res;
        logic        bad;
        if (!rst_n) begin
            m_ff <= 0; m_frm <= 0; m_fexc <= 0; m_busy <= 0;
            m_trap <= 0; m_rdata <= 0; m_err <= 0; m_live <= 1;
        end else begin
            acc  = flags_valid ? {invalid, div_zero, overflow, underflow, inexact} : 5'd0;
            nff  = m_ff;
            nfrm = m_frm;
            nexc = m_fexc;
            if (!m_busy && csr_req) begin
                bad = 1'b0;
                old = 32'd0;
                case (csr_addr)
                    12'h001: old = 32'(m_ff);
                    12'h002: old = 32'(m_frm);
                    12'h003: old = 32'(m_frm) * 32'd32 + 32'(m_ff);
`ifdef FPU_FCSR_TRAP_EN
                    12'h800: old = 32'(m_fexc);
`endif
                    default: bad = 1'b1;
                endcase
                case (csr_op)
                    2'd1:    res = csr_wdata;
                    2'd2:    res = old | csr_wdata;
                    2'd3:    res = old & ~csr_wdata;
                    default: res = old;
                endcase
                if (!bad) begin
                    case (csr_addr)
                        12'h001: nff = res[4:0];
                        12'h002: nfrm = res[2:0];
                        12'h003: begin nfrm = res[7:5]; nff = res[4:0]; end
                        12'h800: nexc = res[4:0];
                        default: ;
                    endcase
                end
                m_rdata <= bad ? 32'd0 : old;
                m_err   <= bad;
                m_busy  <= 1'b1;
            end else if (m_busy && csr_rready) begin
                m_busy <= 1'b0;
            end
            m_trap <= |(acc & ~m_ff & m_fexc);
            m_ff   <= nff | acc;
            m_frm  <= nfrm;
            m_fexc <= nexc;
        end
    end

    always @(negedge clk) begin
        if (rst_n && m_live) begin
            chk("ready", 32'(csr_ready), 32'(!m_busy));
            chk("rvalid", 32'(csr_rvalid), 32'(m_busy));
            chk("state", 32'(dbg_state), 32'(m_busy));
            chk("fflags", 32'(fflags), 32'(m_ff));
            chk("frm", 32'(frm), 32'(m_frm));
            chk("frm_illegal", 32'(frm_illegal), 32'(m_frm > 3'd4));
            chk("trap", 32'(trap), 32'(m_trap));
            if (m_busy) begin
                chk("rdata", csr_rdata, m_rdata);
                chk("err", 32'(csr_err), 32'(m_err));
            end
        end
    end

    task automatic set_flags(input logic [4:0] f);
        flags_valid = |f;
        {invalid, div_zero, overflow, underflow, inexact} = f;
    endtask

    task automatic flag_pulse(input logic [4:0] f);
        @(posedge clk); #1;
        set_flags(f);
        @(posedge clk); #1;
        set_flags(5'd0);
    endtask

    // Full transaction with immediate consumption; acc is raised in the accept cycle.
    task automatic csr_txn(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd,
                           input logic [4:0] acc, output logic [31:0] rd, output logic er);
        @(posedge clk); #1;
        csr_req = 1'b1; csr_addr = a; csr_op = op; csr_wdata = wd;
        set_flags(acc);
        @(posedge clk); #1;
        csr_req = 1'b0;
        set_flags(5'd0);
        rd = csr_rdata;
        er = csr_err;
        csr_rready = 1'b1;
        @(posedge clk); #1;
        csr_rready = 1'b0;
    endtask

    logic [31:0] rd, first;
    logic        er;

    initial begin
        rst_n = 1'b0; csr_req = 0; csr_rready = 0; csr_addr = 0; csr_op = 0; csr_wdata = 0;
        set_flags(5'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_fflags", 32'(fflags), 32'd0);
        chk("rst_frm", 32'(frm), 32'd0);
        chk("rst_ready", 32'(csr_ready), 32'd1);
        chk("rst_rvalid", 32'(csr_rvalid), 32'd0);

        csr_txn(12'h003, 2'd0, 32'd0, 5'd0, rd, er);
        chk("rd_fcsr_reset", rd, 32'h0);
        chk("rd_fcsr_err", 32'(er), 32'd0);

        flag_pulse(5'b00101);
        flag_pulse(5'b10000);
        chk("accrue", 32'(fflags), 32'h15);
        csr_txn(12'h001, 2'd0, 32'd0, 5'd0, rd, er);
        chk("rd_fflags", rd, 32'h15);

        csr_txn(12'h003, 2'd1, 32'hE3, 5'd0, rd, er);
        chk("wr_fcsr_old", rd, 32'h15);
        chk("wr_fcsr_frm", 32'(frm), 32'd7);
        chk("wr_fcsr_illegal", 32'(frm_illegal), 32'd1);
        chk("wr_fcsr_ff", 32'(fflags), 32'h03);

        csr_txn(12'h001, 2'd3, 32'h1F, 5'b01000, rd, er);
        chk("clr_collide_old", rd, 32'h03);
        chk("clr_collide_ff", 32'(fflags), 32'h08);

        // Stalled response with a competing request that must not be taken.
        @(posedge clk); #1;
        csr_req = 1'b1; csr_addr = 12'h003; csr_op = 2'd0; csr_wdata = 0;
        @(posedge clk); #1;
        csr_addr = 12'h002; csr_op = 2'd1; csr_wdata = 32'd0;
        first = csr_rdata;
        chk("stall_rdata0", first, 32'hE8);
        for (int i = 0; i < 4; i++) begin
            chk("stall_ready", 32'(csr_ready), 32'd0);
            chk("stall_rvalid", 32'(csr_rvalid), 32'd1);
            chk("stall_rdata", csr_rdata, first);
            @(posedge clk); #1;
        end
        csr_req = 1'b0; csr_rready = 1'b1;
        @(posedge clk); #1;
        csr_rready = 1'b0;
        chk("stall_frm_kept", 32'(frm), 32'd7);

        csr_txn(12'h7C0, 2'd0, 32'd0, 5'd0, rd, er);
        chk("bad_addr_err", 32'(er), 32'd1);
        chk("bad_addr_rdata", rd, 32'd0);
        chk("bad_addr_ff", 32'(fflags), 32'h08);
        chk("bad_addr_frm", 32'(frm), 32'd7);

        csr_txn(12'h002, 2'd2, 32'h1, 5'd0, rd, er);
        chk("set_frm_old", rd, 32'd7);
        csr_txn(12'h002, 2'd1, 32'h0, 5'd0, rd, er);
        chk("wr_frm", 32'(frm), 32'd0);
        chk("wr_frm_legal", 32'(frm_illegal), 32'd0);
        csr_txn(12'h003, 2'd2, 32'h41, 5'd0, rd, er);
        chk("set_fcsr_old", rd, 32'h08);
        chk("set_fcsr_frm", 32'(frm), 32'd2);
        chk("set_fcsr_ff", 32'(fflags), 32'h09);

`ifdef FPU_FCSR_TRAP_EN
        csr_txn(12'h800, 2'd1, 32'h10, 5'd0, rd, er);
        chk("fexc_wr_err", 32'(er), 32'd0);
        @(posedge clk); #1;
        set_flags(5'b10000);
        @(posedge clk); #1;
        set_flags(5'd0);
        chk("trap_pulse", 32'(trap), 32'd1);
        @(posedge clk); #1;
        chk("trap_one_cycle", 32'(trap), 32'd0);
        set_flags(5'b10000);
        @(posedge clk); #1;
        set_flags(5'd0);
        chk("trap_no_repeat", 32'(trap), 32'd0);
`else
        csr_txn(12'h800, 2'd0, 32'd0, 5'd0, rd, er);
        chk("fexc_absent_err", 32'(er), 32'd1);
        @(posedge clk); #1;
        set_flags(5'b10000);
        @(posedge clk); #1;
        set_flags(5'd0);
        chk("trap_tied", 32'(trap), 32'd0);
`endif

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
